// File: rtl/ddr_chk_pkg.sv
// ddr_chk_pkg: FSM states, AXI encodings and the deterministic test data pattern
package ddr_chk_pkg;
   typedef enum logic [2:0] {IDLE, WA, WD, WB, RA, RD, DONE, FAIL} state_t;
   localparam logic [2:0] AXI_SIZE_16B   = 3'd4;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   // each 32-bit lane tags burst, beat and lane so swapped or misplaced data is visible
   function automatic logic [127:0] pattern(input logic [31:0] seed, input logic [15:0] b, input logic [7:0] k);
      logic [127:0] p;
      for (int i = 0; i < 4; i++) p[i*32 +: 32] = seed ^ {b, k, 6'b0, 2'(i)};
      return p;
   endfunction
endpackage

// File: rtl/ddr_chk_pattern_gen.sv
// ddr_chk_pattern_gen: (burst, beat) -> 128-bit beat, shared by write and compare paths
module ddr_chk_pattern_gen
   import ddr_chk_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hA5A5_0000
) (
   input  logic [15:0]  i_b,
   input  logic [7:0]   i_k,
   output logic [127:0] o_data
);
   assign o_data = pattern(SEED, i_b, i_k);
endmodule

// File: rtl/ddr_axi_mem_checker.sv
// ddr_axi_mem_checker: writes a pattern over a region in INCR bursts, reads it back and compares.
// One address in flight at a time; a sticky error flag keeps FAIL correct past err_cnt saturation.
module ddr_axi_mem_checker
   import ddr_chk_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int          NUM_BURSTS = 16,
   parameter int          BURST_LEN  = 15,
   parameter logic [7:0]  AXI_ID     = 8'h00,
   parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
   input  logic         io_memoryClk,
   input  logic         memoryClk_rstn,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         memoryCheckerPass,
   output logic [15:0]  err_cnt,
   output logic         io_ddrA_arw_valid,
   input  logic         io_ddrA_arw_ready,
   output logic [31:0]  io_ddrA_arw_payload_addr,
   output logic [7:0]   io_ddrA_arw_payload_id,
   output logic [7:0]   io_ddrA_arw_payload_len,
   output logic [2:0]   io_ddrA_arw_payload_size,
   output logic [1:0]   io_ddrA_arw_payload_burst,
   output logic [1:0]   io_ddrA_arw_payload_lock,
   output logic         io_ddrA_arw_payload_write,
   output logic         io_ddrA_w_valid,
   input  logic         io_ddrA_w_ready,
   output logic [127:0] io_ddrA_w_payload_data,
   output logic [7:0]   io_ddrA_w_payload_id,
   output logic [15:0]  io_ddrA_w_payload_strb,
   output logic         io_ddrA_w_payload_last,
   input  logic         io_ddrA_b_valid,
   output logic         io_ddrA_b_ready,
   input  logic [7:0]   io_ddrA_b_payload_id,
   input  logic         io_ddrA_r_valid,
   output logic         io_ddrA_r_ready,
   input  logic [127:0] io_ddrA_r_payload_data,
   input  logic [7:0]   io_ddrA_r_payload_id,
   input  logic [1:0]   io_ddrA_r_payload_resp,
   input  logic         io_ddrA_r_payload_last
);
   localparam logic [31:0] STRIDE = 32'((BURST_LEN + 1) * 16);
   localparam logic [15:0] LAST_B = 16'(NUM_BURSTS - 1);
   localparam logic [7:0]  LAST_K = 8'(BURST_LEN);

   state_t       r_state, w_next;
   logic [15:0]  r_b, r_err_cnt;
   logic [7:0]   r_k;
   logic [31:0]  r_addr;
   logic         r_err_flag;
   logic [127:0] w_pattern;
   logic         w_idle, w_start, w_last_b, w_k_last, w_arw_hs, w_w_hs, w_b_hs, w_r_hs;
   logic         w_b_err, w_r_err, w_r_end;

   ddr_chk_pattern_gen #(.SEED(SEED)) u_pat (.i_b(r_b), .i_k(r_k), .o_data(w_pattern));

   assign w_idle   = (r_state == IDLE) || (r_state == DONE) || (r_state == FAIL);
   assign w_start  = start && w_idle;
   assign w_last_b = (r_b == LAST_B);
   assign w_k_last = (r_k == LAST_K);
   assign w_arw_hs = io_ddrA_arw_valid && io_ddrA_arw_ready;
   assign w_w_hs   = io_ddrA_w_valid && io_ddrA_w_ready;
   assign w_b_hs   = io_ddrA_b_valid && io_ddrA_b_ready;
   assign w_r_hs   = io_ddrA_r_valid && io_ddrA_r_ready;
   assign w_b_err  = w_b_hs && (io_ddrA_b_payload_id != AXI_ID);
   assign w_r_err  = w_r_hs && ((io_ddrA_r_payload_data != w_pattern) || (io_ddrA_r_payload_id != AXI_ID) ||
                     (io_ddrA_r_payload_resp != AXI_RESP_OKAY) || (io_ddrA_r_payload_last != w_k_last));
   // a final-index beat without last still closes the burst so the checker cannot hang
   assign w_r_end  = w_r_hs && (io_ddrA_r_payload_last || w_k_last);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE, FAIL: if (start) w_next = WA;
         WA: if (w_arw_hs) w_next = WD;
         WD: if (w_w_hs && w_k_last) w_next = WB;
         WB: if (w_b_hs) w_next = w_last_b ? RA : WA;
         RA: if (w_arw_hs) w_next = RD;
         RD: if (w_r_end) w_next = !w_last_b ? RA : (r_err_flag || w_r_err) ? FAIL : DONE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge io_memoryClk or negedge memoryClk_rstn)
      if (!memoryClk_rstn) begin
         r_state    <= IDLE;
         r_b        <= '0;
         r_k        <= '0;
         r_addr     <= '0;
         r_err_cnt  <= '0;
         r_err_flag <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_b        <= '0;
            r_k        <= '0;
            r_addr     <= BASE_ADDR;
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
         end else begin
            if (w_arw_hs) r_k <= '0;
            if (w_w_hs || w_r_hs) r_k <= r_k + 8'd1;
            if (w_b_hs || w_r_end) begin
               r_b    <= w_last_b ? '0 : r_b + 16'd1;
               r_addr <= w_last_b ? BASE_ADDR : r_addr + STRIDE;
            end
            if (w_b_err || w_r_err) begin
               r_err_flag <= 1'b1;
               if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
         end
      end

   assign busy                      = !w_idle;
   assign done                      = (r_state == DONE) || (r_state == FAIL);
   assign memoryCheckerPass         = (r_state == DONE);
   assign err_cnt                   = r_err_cnt;
   assign io_ddrA_arw_valid         = (r_state == WA) || (r_state == RA);
   assign io_ddrA_arw_payload_addr  = r_addr;
   assign io_ddrA_arw_payload_id    = AXI_ID;
   assign io_ddrA_arw_payload_len   = LAST_K;
   assign io_ddrA_arw_payload_size  = AXI_SIZE_16B;
   assign io_ddrA_arw_payload_burst = AXI_BURST_INCR;
   assign io_ddrA_arw_payload_lock  = 2'b00;
   assign io_ddrA_arw_payload_write = (r_state == WA);
   assign io_ddrA_w_valid           = (r_state == WD);
   assign io_ddrA_w_payload_data    = (r_state == WD) ? w_pattern : '0;
   assign io_ddrA_w_payload_id      = AXI_ID;
   assign io_ddrA_w_payload_strb    = 16'hFFFF;
   assign io_ddrA_w_payload_last    = (r_state == WD) && w_k_last;
   assign io_ddrA_b_ready           = (r_state == WB);
   assign io_ddrA_r_ready           = (r_state == RD);
endmodule
